// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Accepts a value on a valid/ready handshake, produces six registered BCD digits
// and a one-cycle out_valid pulse DATA_W+1 edges after acceptance.
// Optional leading-zero blanking mask enabled with `define LEADING_ZERO_BLANK_EN.
module bin2bcd_seq #(
  parameter int unsigned DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data,
  output logic              out_valid,
  output logic              ovf,
  output logic [3:0]        unit,
  output logic [3:0]        ten,
  output logic [3:0]        hun,
  output logic [3:0]        thou,
  output logic [3:0]        ten_thou,
  output logic [3:0]        hun_thou
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [5:0]        blank
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_sh;
  logic [23:0]       r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_pend;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_ovf;
  logic [23:0]       r_digits;

  logic [31:0]       w_data_ext;
  logic              w_ovf;
  logic [19:0]       w_adj_lo;
  logic [2:0]        w_adj_top;
  logic [23:0]       w_bcd_next;

  assign w_data_ext = 32'(data);
  assign w_ovf      = (w_data_ext > 32'd999999);

  // Add-3 correction on every nibble >= 5, then shift the next binary bit in.
  // Only the low three bits of the top nibble are kept: its MSB is shifted out.
  always_comb begin
    w_adj_lo = r_bcd[19:0];
    for (int unsigned i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj_lo[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_adj_top = (r_bcd[23:20] >= 4'd5) ? (r_bcd[22:20] + 3'd3) : r_bcd[22:20];
    w_bcd_next = {w_adj_top, w_adj_lo, r_sh[DATA_W-1]};
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0] w_blank;
  logic [5:0] r_blank;

  // Digit i is blanked when it and every higher digit are zero; unit never blanks.
  always_comb begin
    w_blank = '0;
    for (int unsigned i = 1; i < 6; i++) begin
      w_blank[i] = ((r_bcd >> (4 * i)) == '0);
    end
  end

  assign blank = r_blank;
`endif

  // Control FSM, datapath scratch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_ovf_pend  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_digits    <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      r_blank     <= 6'b111110;
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh       <= data;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(DATA_W);
            r_ovf_pend <= w_ovf;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_next;
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_digits    <= r_ovf_pend ? 24'h999999 : r_bcd;
          r_ovf       <= r_ovf_pend;
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
          r_blank     <= r_ovf_pend ? 6'b000000 : w_blank;
`endif
          r_state     <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;
  assign unit      = r_digits[3:0];
  assign ten       = r_digits[7:4];
  assign hun       = r_digits[11:8];
  assign thou      = r_digits[15:12];
  assign ten_thou  = r_digits[19:16];
  assign hun_thou  = r_digits[23:20];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq (default DATA_W=20): table-driven vectors plus
// hand-written busy, back-to-back and reset-abort sequences, scoreboard-checked.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [19:0] data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        ovf;
  logic [3:0]  unit, ten, hun, thou, ten_thou, hun_thou;
`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0]  blank;
`endif

  bin2bcd_seq #(.DATA_W(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .out_valid(out_valid),
    .ovf      (ovf),
    .unit     (unit),
    .ten      (ten),
    .hun      (hun),
    .thou     (thou),
    .ten_thou (ten_thou),
    .hun_thou (hun_thou)
`ifdef LEADING_ZERO_BLANK_EN
    ,
    .blank    (blank)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] din;
    logic [23:0] bcd;
    logic        o;
  } vec_t;

  typedef struct {
    logic [23:0] bcd;
    logic        o;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] last_bcd = '0;
  vec_t        tbl[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [5:0] exp_blank(input logic [23:0] bcd, input logic o);
    logic [5:0] b;
    b = '0;
    if (!o) begin
      for (int i = 1; i < 6; i++) b[i] = ((bcd >> (4 * i)) == 24'd0);
    end
    return b;
  endfunction
`endif

  // Reference conversion by repeated division.
  function automatic logic [23:0] model_bcd(input logic [19:0] d);
    int unsigned v;
    logic [23:0] r;
    v = d;
    r = '0;
    if (v > 999999) return 24'h999999;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] digits();
    return {hun_thou, ten_thou, thou, hun, ten, unit};
  endfunction

  // Scoreboard consumer: every out_valid pulse must match the oldest pending entry.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", cyc, e.due);
        check("digits", 32'(digits()), 32'(e.bcd));
        check("ovf", 32'(ovf), 32'(e.o));
`ifdef LEADING_ZERO_BLANK_EN
        check("blank", 32'(blank), 32'(exp_blank(e.bcd, e.o)));
`endif
        last_bcd = e.bcd;
      end
    end
  end

  task automatic push(input logic [23:0] bcd, input logic o, input int unsigned due);
    exp_t e;
    e.bcd = bcd;
    e.o   = o;
    e.due = due;
    sb.push_back(e);
  endtask

  // One-cycle in_valid pulse while the converter is idle.
  task automatic send(input logic [19:0] d, input bit expect_out, input logic [23:0] bcd,
                      input logic o);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    data     = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (expect_out) push(bcd, o, cyc + 21);
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int unsigned a;
    logic [19:0] r;

    tbl[0] = '{20'd0,       24'h000000, 1'b0};
    tbl[1] = '{20'd123456,  24'h123456, 1'b0};
    tbl[2] = '{20'd999999,  24'h999999, 1'b0};
    tbl[3] = '{20'd1000000, 24'h999999, 1'b1};
    tbl[4] = '{20'd1048575, 24'h999999, 1'b1};
    tbl[5] = '{20'd9,       24'h000009, 1'b0};
    tbl[6] = '{20'd10,      24'h000010, 1'b0};
    tbl[7] = '{20'd99999,   24'h099999, 1'b0};
    tbl[8] = '{20'd100000,  24'h100000, 1'b0};
    tbl[9] = '{20'd524288,  24'h524288, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_digits", 32'(digits()), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
    check("rst_blank", 32'(blank), 32'b111110);
`endif
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].din, 1'b1, tbl[i].bcd, tbl[i].o);
      wait_done();
    end

    // Random values against the division model.
    for (int i = 0; i < 6; i++) begin
      r = 20'($urandom_range(0, 1048575));
      send(r, 1'b1, model_bcd(r), (r > 20'd999999));
      wait_done();
    end

    // Busy: second pulse while converting 305 is ignored; in_ready low E0..E20.
    send(20'd305, 1'b1, 24'h000305, 1'b0);
    a = cyc;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (cyc - a == 4) begin
        data = 20'd77;
        in_valid = 1'b1;
      end
      if (cyc - a == 5) in_valid = 1'b0;
      if (cyc - a == 10) check("hold_digits", 32'(digits()), 32'(last_bcd));
      if (cyc - a == 20) check("busy_in_ready", 32'(in_ready), 32'd0);
      if (cyc - a == 21) check("ready_again", 32'(in_ready), 32'd1);
    end
    wait_done();
    repeat (30) @(negedge clk);

    // Back-to-back: hold in_valid, 42 then 58, accepted 22 edges apart.
    @(negedge clk);
    data = 20'd42;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    push(24'h000042, 1'b0, cyc + 21);
    data = 20'd58;
    repeat (22) @(posedge clk);
    #1;
    push(24'h000058, 1'b0, cyc + 21);
    in_valid = 1'b0;
    wait_done();

    // Reset mid-conversion aborts with no out_valid.
    send(20'd500, 1'b1, 24'h000500, 1'b0);
    wait_done();
    send(20'd654321, 1'b0, '0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_digits", 32'(digits()), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_abort_digits", 32'(digits()), 32'd0);
    send(20'd7, 1'b1, 24'h000007, 1'b0);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
